// File: rtl/debug_trace_uart_if.sv
// Debug-bus capture port of the trace recorder: capture strobe, payload, mode and trigger.
interface debug_trace_uart_if #(
  parameter int DATA_W = 32,
  parameter int TS_W   = 32
);
  logic              wrap_mode;
  logic              rec_we;
  logic [DATA_W-1:0] rec_data;
  logic [TS_W-1:0]   rec_ts;
  logic              trig;

  modport master (
    output wrap_mode, rec_we, rec_data, rec_ts, trig
  );

  modport slave (
    input wrap_mode, rec_we, rec_data, rec_ts, trig
  );
endinterface

// File: rtl/debug_trace_uart.sv
// Trace recorder: captures {timestamp, data} into a RAM, then on trigger dumps every entry
// oldest-first as "TS DATA\r\n" uppercase hex lines over an 8N1 UART transmitter.
module debug_trace_uart #(
  parameter int DATA_W   = 32,
  parameter int TS_W     = 32,
  parameter int DEPTH    = 1024,
  parameter int BAUD_DIV = 868
) (
  input  logic                     CLK,
  input  logic                     RST,
  debug_trace_uart_if.slave        bus,
  output logic                     txd,
  output logic                     recording,
  output logic                     dump_busy,
  output logic                     dump_done,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int TSD      = (TS_W + 3) / 4;
  localparam int DD       = (DATA_W + 3) / 4;
  localparam int LINE_LEN = TSD + DD + 3;
  localparam int LW       = (TSD + DD) * 4;
  localparam int CIW      = $clog2(LINE_LEN);
  localparam int BW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int EW       = DATA_W + TS_W;

  localparam logic [CW-1:0]  COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]  COUNT_ONE  = CW'(1);
  localparam logic [AW-1:0]  PTR_ONE    = AW'(1);
  localparam logic [CIW-1:0] IDX_ONE    = CIW'(1);
  localparam logic [CIW-1:0] IDX_SPACE  = CIW'(TSD);
  localparam logic [CIW-1:0] IDX_CR     = CIW'(LINE_LEN - 2);
  localparam logic [CIW-1:0] IDX_LF     = CIW'(LINE_LEN - 1);
  localparam logic [BW-1:0]  BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0]  BAUD_ONE   = BW'(1);

  typedef enum logic [2:0] {
    REC, LOAD, FETCH, EMIT, NEXT, DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            overflow_reg, overflow_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   remain_reg, remain_next;
  logic [LW-1:0]   line_reg, line_next;
  logic [CIW-1:0]  char_idx_reg, char_idx_next;

  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   ram_q;
  logic            mem_we;
  logic [EW-1:0]   mem_wdata;

  logic            emit_valid;
  logic [7:0]      emit_byte;
  logic [3:0]      nibble;
  logic            is_nibble;
  logic [TSD*4-1:0] ts_pad;
  logic [DD*4-1:0]  data_pad;

  logic [7:0]      hold_reg;
  logic            hold_valid_reg;
  logic            tx_active_reg;
  logic [9:0]      tx_shift_reg;
  logic [3:0]      bit_idx_reg;
  logic [BW-1:0]   baud_cnt_reg;
  logic            tx_tick;
  logic            tx_last_tick;
  logic            tx_drained;

  assign mem_wdata = {bus.rec_ts, bus.rec_data};
  assign ts_pad    = (TSD*4)'(ram_q[EW-1:DATA_W]);
  assign data_pad  = (DD*4)'(ram_q[DATA_W-1:0]);
  assign nibble    = line_reg[LW-1 -: 4];
  assign is_nibble = (char_idx_reg < IDX_SPACE) ||
                     ((char_idx_reg > IDX_SPACE) && (char_idx_reg < IDX_CR));

  assign tx_tick      = tx_active_reg && (baud_cnt_reg == BAUD_LAST);
  assign tx_last_tick = tx_tick && (bit_idx_reg == 4'd9);
  // The last stop bit is finishing (or already done) with nothing queued behind it.
  assign tx_drained   = !hold_valid_reg && (!tx_active_reg || tx_last_tick);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= REC;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      rd_ptr_reg   <= '0;
      remain_reg   <= '0;
      line_reg     <= '0;
      char_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      rd_ptr_reg   <= rd_ptr_next;
      remain_reg   <= remain_next;
      line_reg     <= line_next;
      char_idx_reg <= char_idx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    rd_ptr_next   = rd_ptr_reg;
    remain_next   = remain_reg;
    line_next     = line_reg;
    char_idx_next = char_idx_reg;
    mem_we        = 1'b0;
    emit_valid    = 1'b0;
    emit_byte     = 8'h00;

    case (state_reg)
      REC: begin
        if (bus.rec_we) begin
          if (count_reg != COUNT_FULL) begin
            mem_we      = 1'b1;
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
            count_next  = count_reg + COUNT_ONE;
          end else begin
            overflow_next = 1'b1;
            if (bus.wrap_mode) begin
              mem_we      = 1'b1;
              wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
          end
        end
        if (bus.trig) begin
          state_next = LOAD;
        end
      end

      LOAD: begin
        remain_next = count_reg;
        // A full circular buffer has its oldest entry at the write pointer.
        rd_ptr_next = (count_reg == COUNT_FULL) ? wr_ptr_reg : '0;
        state_next  = (count_reg == '0) ? DONE : FETCH;
      end

      FETCH: begin
        line_next     = {ts_pad, data_pad};
        char_idx_next = '0;
        state_next    = EMIT;
      end

      EMIT: begin
        if (!hold_valid_reg) begin
          emit_valid    = 1'b1;
          char_idx_next = char_idx_reg + IDX_ONE;
          if (is_nibble) begin
            emit_byte = (nibble < 4'd10) ? {4'h3, nibble} : (8'h37 + {4'h0, nibble});
            line_next = line_reg << 4;
          end else if (char_idx_reg == IDX_SPACE) begin
            emit_byte = 8'h20;
          end else if (char_idx_reg == IDX_CR) begin
            emit_byte = 8'h0D;
          end else begin
            emit_byte = 8'h0A;
          end
          if (char_idx_reg == IDX_LF) begin
            state_next = NEXT;
          end
        end
      end

      NEXT: begin
        if (remain_reg == COUNT_ONE) begin
          // Hold the busy state until the final stop bit has fully left the wire.
          if (tx_drained) begin
            remain_next = '0;
            state_next  = DONE;
          end
        end else begin
          remain_next = remain_reg - COUNT_ONE;
          rd_ptr_next = rd_ptr_reg + PTR_ONE;
          state_next  = FETCH;
        end
      end

      DONE: begin
        state_next = DONE;
      end

      default: begin
        state_next = REC;
      end
    endcase
  end

  // Trace RAM: synchronous write in REC, registered read addressed one cycle ahead of FETCH.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[wr_ptr_reg] <= mem_wdata;
    end
    ram_q <= mem[rd_ptr_next];
  end

  // 8N1 transmitter with a one-byte holding register so bytes go out back-to-back.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_reg       <= 8'h00;
      hold_valid_reg <= 1'b0;
      tx_active_reg  <= 1'b0;
      tx_shift_reg   <= 10'h3FF;
      bit_idx_reg    <= 4'd0;
      baud_cnt_reg   <= '0;
    end else begin
      if (emit_valid) begin
        hold_reg       <= emit_byte;
        hold_valid_reg <= 1'b1;
      end
      if ((!tx_active_reg || tx_last_tick) && hold_valid_reg) begin
        tx_shift_reg   <= {1'b1, hold_reg, 1'b0};
        tx_active_reg  <= 1'b1;
        bit_idx_reg    <= 4'd0;
        baud_cnt_reg   <= '0;
        hold_valid_reg <= 1'b0;
      end else if (tx_last_tick) begin
        tx_active_reg <= 1'b0;
        baud_cnt_reg  <= '0;
      end else if (tx_tick) begin
        tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
        bit_idx_reg  <= bit_idx_reg + 4'd1;
        baud_cnt_reg <= '0;
      end else if (tx_active_reg) begin
        baud_cnt_reg <= baud_cnt_reg + BAUD_ONE;
      end
    end
  end

  assign txd       = tx_active_reg ? tx_shift_reg[0] : 1'b1;
  assign recording = (state_reg == REC);
  assign dump_busy = (state_reg != REC) && (state_reg != DONE);
  assign dump_done = (state_reg == DONE);
  assign overflow  = overflow_reg;
  assign count     = count_reg;

endmodule
